// File: rtl/div5_pkg.sv
// Shared constants, FSM state type and sizing helper for the divide-by-5 engine.
package div5_pkg;

   localparam int unsigned DIVISOR = 5;
   localparam int unsigned DIGIT_W = 3;
   localparam int unsigned REM_W   = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of 3-bit digit iterations needed to cover a dividend of the given width.
   function automatic int unsigned steps(input int unsigned width);
      return (width + DIGIT_W - 1) / DIGIT_W;
   endfunction

endpackage

// File: rtl/div5_digit_lut.sv
// Combinational digit step: divides {rem, digit} (0..39) by 5.
module div5_digit_lut
   import div5_pkg::*;
(
   input  logic [REM_W-1:0]   rem,
   input  logic [DIGIT_W-1:0] digit,
   output logic [DIGIT_W-1:0] qd,
   output logic [REM_W-1:0]   nr
);

   logic [REM_W+DIGIT_W-1:0] v;

   // One lookup: quotient digit and next remainder; rem 5..7 cannot occur and yields 0.
   always_comb begin
      v  = {rem, digit};
      qd = '0;
      nr = '0;
      if (rem < REM_W'(DIVISOR)) begin
         qd = DIGIT_W'(v / (REM_W + DIGIT_W)'(DIVISOR));
         nr = REM_W'(v % (REM_W + DIGIT_W)'(DIVISOR));
      end
   end

endmodule

// File: rtl/div5_seq_ctrl.sv
// Sequential divide-by-5: walks the dividend MSB-first one 3-bit digit per cycle.
module div5_seq_ctrl
   import div5_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_dividend,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quotient,
   output logic [REM_W-1:0] out_remainder,
   output logic             busy
);

   localparam int unsigned STEPS = steps(WIDTH);
   localparam int unsigned QW    = DIGIT_W * STEPS;
   localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   state_t             state;
   logic [QW-1:0]      dvd;
   // Quotient padding bits above WIDTH are provably zero, so only WIDTH bits are kept.
   logic [WIDTH-1:0]   quo;
   logic [REM_W-1:0]   rem;
   logic [CNT_W-1:0]   cnt;
   logic [DIGIT_W-1:0] qd;
   logic [REM_W-1:0]   nr;

   div5_digit_lut u_lut (
      .rem   (rem),
      .digit (dvd[QW-1 -: DIGIT_W]),
      .qd    (qd),
      .nr    (nr)
   );

   // Handshake FSM plus dividend/quotient shift datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         dvd   <= '0;
         quo   <= '0;
         rem   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  dvd   <= QW'(in_dividend);
                  rem   <= '0;
                  cnt   <= CNT_W'(STEPS - 1);
                  state <= RUN;
               end
            end
            RUN: begin
               dvd <= dvd << DIGIT_W;
               quo <= WIDTH'({quo, qd});
               rem <= nr;
               if (cnt == '0) begin
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Status outputs decode directly from the state register.
   always_comb begin
      in_ready      = (state == IDLE);
      out_valid     = (state == DONE);
      busy          = (state == RUN) || (state == DONE);
      out_quotient  = quo;
      out_remainder = rem;
   end

endmodule

// File: tb/tb_div5_seq_ctrl.sv
// Self-checking bench for div5_seq_ctrl (WIDTH=64 and WIDTH=8 instances).
module tb_div5_seq_ctrl;

   localparam int unsigned STEPS64 = 22;
   localparam int unsigned STEPS8  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
   logic [63:0] in_dividend = '0, out_quotient;
   logic [2:0]  out_remainder;

   logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, busy8;
   logic [7:0]  in_dividend8 = '0, out_quotient8;
   logic [2:0]  out_remainder8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   div5_seq_ctrl #(.WIDTH(64)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_dividend   (in_dividend),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_quotient  (out_quotient),
      .out_remainder (out_remainder),
      .busy          (busy)
   );

   div5_seq_ctrl #(.WIDTH(8)) dut8 (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid8),
      .in_ready      (in_ready8),
      .in_dividend   (in_dividend8),
      .out_valid     (out_valid8),
      .out_ready     (out_ready8),
      .out_quotient  (out_quotient8),
      .out_remainder (out_remainder8),
      .busy          (busy8)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rand64();
      logic [63:0] v;
      case ($urandom_range(3))
         0:       v = {$urandom, $urandom};
         1:       v = 64'($urandom_range(100));
         2:       v = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(20));
         default: v = 64'($urandom);
      endcase
      return v;
   endfunction

   // Full transaction on the 64-bit instance with out_ready held high.
   task automatic run64(input logic [63:0] d, input string tag);
      int lat;
      @(negedge clk);
      chk({tag, "_in_ready"}, in_ready, 1);
      in_valid    = 1'b1;
      in_dividend = d;
      out_ready   = 1'b1;
      @(negedge clk);
      in_valid    = 1'b0;
      in_dividend = {$urandom, $urandom};
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, lat, STEPS64);
      chk({tag, "_quot"}, out_quotient, d / 64'd5);
      chk({tag, "_rem"}, out_remainder, d % 64'd5);
      @(negedge clk);
      chk({tag, "_idle_after"}, in_ready, 1);
   endtask

   // Full transaction on the 8-bit instance.
   task automatic run8(input logic [7:0] d, input bit check_lat);
      int lat;
      in_valid8    = 1'b1;
      in_dividend8 = d;
      @(negedge clk);
      in_valid8    = 1'b0;
      in_dividend8 = 8'($urandom);
      lat = 0;
      while (out_valid8 !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (check_lat) chk("w8_latency", lat, STEPS8);
      chk("w8_quot", out_quotient8, d / 8'd5);
      chk("w8_rem", out_remainder8, d % 8'd5);
      @(negedge clk);
   endtask

   initial begin
      logic [63:0] q_exp[$];
      logic [2:0]  r_exp[$];
      logic [63:0] d, q0;
      logic [2:0]  r0;
      int sent, got, cyc, lat, seen;

      // Reset state
      #1 rst = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_quot", out_quotient, 0);
      chk("rst_rem", out_remainder, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Directed dividends
      run64(64'd100, "d100");
      run64(64'hFFFF_FFFF_FFFF_FFFF, "ones");
      run64(64'd7, "d7");
      run64(64'd0, "d0");

      // Backpressure with in_valid high throughout DONE
      d = rand64();
      @(negedge clk);
      in_valid = 1'b1; in_dividend = d; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("bp_latency", lat, STEPS64);
      q0 = d / 64'd5;
      r0 = 3'(d % 64'd5);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_dividend = {$urandom, $urandom};
         @(negedge clk);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_busy", busy, 1);
         chk("bp_quot", out_quotient, q0);
         chk("bp_rem", out_remainder, r0);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      chk("bp_in_ready_after", in_ready, 1);
      chk("bp_out_valid_after", out_valid, 0);
      chk("bp_busy_after", busy, 0);

      // Randomized stream against a queue-based reference
      sent = 0; got = 0; cyc = 0;
      while (got < 1000 && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         in_valid    = (sent < 1000) && ($urandom_range(3) != 0);
         in_dividend = rand64();
         out_ready   = ($urandom_range(3) != 0);
         if (in_valid && in_ready) begin
            q_exp.push_back(in_dividend / 64'd5);
            r_exp.push_back(3'(in_dividend % 64'd5));
            sent++;
         end
         if (out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
               chk("stream_spurious", out_valid, 0);
            end else begin
               chk("stream_quot", out_quotient, q_exp.pop_front());
               chk("stream_rem", out_remainder, r_exp.pop_front());
            end
            got++;
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("stream_count", got, 1000);
      chk("stream_leftover", q_exp.size(), 0);
      repeat (3) @(negedge clk);

      // Asynchronous reset in the middle of RUN
      in_valid = 1'b1; in_dividend = 64'd999_999_999;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("mid_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_in_ready", in_ready, 1);
      chk("arst_busy", busy, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_quot", out_quotient, 0);
      chk("arst_rem", out_remainder, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen++;
      end
      chk("arst_no_out_valid", seen, 0);
      run64(64'd12345, "d12345");

      // WIDTH=8 instance: 255 with latency, then every dividend
      @(negedge clk);
      run8(8'd255, 1'b1);
      for (int i = 0; i < 256; i++) run8(8'(i), 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div5_seq_ctrl.md
# div5_seq_ctrl

- Sequential divide-by-5 engine built around a 6-input digit lookup.
- Accepts an unsigned dividend over a valid/ready handshake.
- Walks the dividend MSB-first in 3-bit digits, one digit per cycle, carrying a 3-bit remainder; returns quotient and remainder over a second valid/ready handshake.
- It is the sequenced, area-lean counterpart of the fully unrolled constant-division quotient blocks, sharing one digit LUT across all steps.

## Interface
- WIDTH, 64, dividend/quotient width in bits; WIDTH ≥ 3.
- STEPS (localparam), ceil(WIDTH/3), digit iterations per division (22 for WIDTH=64).
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  dividend offered.
- in_ready  output  1  block can accept a dividend.
- in_dividend  input  WIDTH  unsigned dividend.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_quotient  output  WIDTH  floor(dividend/5).
- out_remainder  output  3  dividend mod 5, range 0..4.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, load the dividend zero-extended to 3*STEPS bits into a shift register, clear rem to 0, set cnt=STEPS-1, go to RUN.
  - RUN: each cycle:
    - LUT input is {rem[2:0], top 3 bits of the shift register}, value v in 0..39.
    - LUT output is qd=v/5 (3 bits) and nr=v%5 (3 bits).
    - Shift qd into the quotient LSB end; shift the dividend register left by 3; rem←nr.
    - When cnt==0 on this edge, go to DONE; otherwise cnt decrements.
  - DONE: out_valid=1. On out_valid&out_ready, go to IDLE.
- Result registers:
  - out_quotient is the low WIDTH bits of the 3*STEPS-bit quotient register; the padding bits are always 0.
  - out_remainder=rem.
- in_ready=1 only in IDLE; no bypass from DONE to a new accept in the same cycle.
- in_dividend is sampled only at the accept edge; later changes have no effect.
- out_quotient and out_remainder are stable throughout DONE regardless of inputs.
- In DONE, in_valid is ignored; in RUN, out_ready is ignored.
- Reset at any time: state→IDLE, and all registers clear:
  - cnt and rem to 0;
  - the dividend shift register and quotient register to 0.
- Reset mid-RUN discards the division; no out_valid is produced for it.
- Reset values of outputs:
  - in_ready=1; busy=0; out_valid=0;
  - out_quotient=0; out_remainder=0.

## Timing
- Accept edge T, defined by in_valid&in_ready.
- RUN occupies the edges T+1 … T+STEPS.
- out_valid rises after edge T+STEPS, i.e. 22 cycles after accept for WIDTH=64.
- Minimum issue interval is STEPS+2 cycles: accept, STEPS RUN cycles, 1 DONE cycle with out_ready=1, then IDLE.
- out_valid holds indefinitely under out_ready=0.
- in_ready is 1 the cycle after the output handshake.
- The LUT path is purely combinational, one lookup per cycle, with no registers inside it.

## Structure
- Package div5_pkg holds:
  - DIVISOR=5, DIGIT_W=3, REM_W=3;
  - the state enum {IDLE, RUN, DONE};
  - the function steps(width)=ceil(width/3).
- Sub-module div5_digit_lut: combinational.
  - Inputs rem[2:0] and digit[2:0]; outputs qd[2:0] and nr[2:0].
  - rem inputs 5..7 are unreachable; the outputs for them are don't-care, driven as 0.
- Top contains the FSM, counter, dividend shift register, quotient shift register and handshake logic.

## Test plan
- Dividend 100 → out_quotient=20, out_remainder=0, out_valid rising exactly 22 cycles after accept.
- Dividend 64'hFFFF_FFFF_FFFF_FFFF → quotient 64'h3333_3333_3333_3333, remainder 0; dividend 7 → quotient 1, remainder 2; dividend 0 → quotient 0, remainder 0.
- Backpressure: out_ready held 0 for 5 cycles after out_valid, with in_valid=1 throughout.
  - Outputs stay constant, in_ready stays 0, and no second accept occurs.
  - After the handshake, in_ready=1 on the next cycle.
- Back-to-back stream of 1000 random dividends with random in_valid/out_ready gaps: every result matches the dividend/5 and dividend%5 reference, in order, none lost or duplicated.
- Assert rst at RUN cycle 10 → all outputs return to reset values asynchronously and no out_valid appears. The next dividend 12345 → quotient 2469, remainder 0.
- WIDTH=8 instance (STEPS=3): dividend 255 → quotient 51, remainder 0, out_valid 3 cycles after accept.
